// File: rtl/alu_pkg.sv
// Shared ALU definitions.
// The funct encodings are the same constants the ALU control decoder uses.
// The FSM state type is used by seq_alu.
package alu_pkg;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_SLL = 2'd2;
    localparam logic [1:0] ALU_OR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_shift_unit.sv
// Serial left shifter that moves one bit per cycle.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   load     : capture val into the accumulator and amt into the counter
//   val      : value to be shifted
//   amt      : number of one-bit shifts still to perform
//   acc      : accumulator, holding the shifted value so far
//   busy     : high while the counter is non-zero
module alu_shift_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] val,
    input  logic [SHW-1:0]   amt,
    output logic [WIDTH-1:0] acc,
    output logic             busy
);

    logic [WIDTH-1:0] acc_q;
    logic [SHW-1:0]   count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            count_q <= '0;
        end else if (load) begin
            acc_q   <= val;
            count_q <= amt;
        end else if (count_q != '0) begin
            acc_q   <= acc_q << 1;
            count_q <= count_q - SHW'(1);
        end
    end

    assign acc  = acc_q;
    assign busy = (count_q != '0);

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle execution ALU with a valid/ready handshake on each side.
// Add, sub and OR finish in one execute cycle. Shift left runs serially
// in alu_shift_unit, one bit per cycle.
// Ports:
//   clk, rst       : clock and asynchronous active-high reset
//   in_valid       : request input
//   in_ready       : request ready output, high only in IDLE while out of reset
//   funct          : op code (add/sub/sll/or)
//   src1, src2     : operands; for a shift, the amount is src2[SHW-1:0]
//   out_valid      : result valid output
//   out_ready      : result ready input
//   result, zero   : registered result, and a flag that is high when result is 0
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       funct,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    alu_state_t       state_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             out_valid_q;

    logic [WIDTH-1:0] res_d;
    logic             accept;
    logic [SHW-1:0]   sh_amt;
    logic [WIDTH-1:0] sh_acc;
    logic             sh_busy;

    assign accept = (state_q == IDLE) && in_valid;
    assign sh_amt = (funct == ALU_SLL) ? src2[SHW-1:0] : '0;

    // The shifter loads on every accept. A non-shift op loads a zero count,
    // so busy stays low and EXEC takes a single cycle.
    alu_shift_unit #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shift (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .val  (src1),
        .amt  (sh_amt),
        .acc  (sh_acc),
        .busy (sh_busy)
    );

    always_comb begin
        res_d = '0;
        case (op_q)
            ALU_ADD: res_d = a_q + b_q;
            ALU_SUB: res_d = a_q - b_q;
            ALU_SLL: res_d = sh_acc;
            ALU_OR:  res_d = a_q | b_q;
            default: res_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= ALU_ADD;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q    <= funct;
                        a_q     <= src1;
                        b_q     <= src2;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (!sh_busy) begin
                        result_q    <= res_d;
                        zero_q      <= (res_d == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The rst term drops in_ready as soon as reset is asserted, without
    // waiting for the state register to clear.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  funct;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    int errors = 0;
    int checks = 0;

    seq_alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct     (funct),
        .src1      (src1),
        .src2      (src2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic        exp_zero;
        int          exp_lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [1:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        case (f)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a << b[4:0];
            default: return a | b;
        endcase
    endfunction

    // Issue one op with out_ready high, then measure latency and check the result.
    task automatic run_op(input string name, input logic [1:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic exp_zero, input int exp_lat);
        int  lat;
        bit  ready_seen;
        @(negedge clk);
        check({name, "_in_ready_pre"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        funct    = f;
        src1     = a;
        src2     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        src1     = 32'hDEAD_BEEF;
        src2     = 32'h1234_5678;
        funct    = 2'd0;
        lat        = 0;
        ready_seen = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) ready_seen = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_in_ready_busy"}, {31'd0, ready_seen}, 32'd0);
        check({name, "_result"}, result, exp_res);
        check({name, "_zero"}, {31'd0, zero}, {31'd0, exp_zero});
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  lat;
        int  received;
        bit  got;
        logic [1:0]  rf;
        logic [31:0] ra, rb, rexp;

        vecs[0] = '{2'd0, 32'd5,          32'd7,          32'd12,         1'b0, 1};
        vecs[1] = '{2'd1, 32'd3,          32'd3,          32'd0,          1'b1, 1};
        vecs[2] = '{2'd1, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0, 1};
        vecs[3] = '{2'd0, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1};
        vecs[4] = '{2'd2, 32'h1,          32'h0000_00E4,  32'h10,         1'b0, 5};
        vecs[5] = '{2'd2, 32'h1,          32'h0000_0000,  32'h1,          1'b0, 1};
        vecs[6] = '{2'd2, 32'h1,          32'h0000_001F,  32'h8000_0000,  1'b0, 32};
        vecs[7] = '{2'd2, 32'h8000_0003,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 32};
        vecs[8] = '{2'd2, 32'h8000_0000,  32'h0000_0001,  32'h0,          1'b1, 2};
        vecs[9] = '{2'd3, 32'hF0F0_0000,  32'h0000_0F0F,  32'hF0F0_0F0F,  1'b0, 1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        funct     = 2'd0;
        src1      = '0;
        src2      = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b,
                   vecs[i].exp_res, vecs[i].exp_zero, vecs[i].exp_lat);
        end

        // Stall: OR held in DONE for 4 cycles while a new request waits.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        funct     = 2'd3;
        src1      = 32'hF0F0_0000;
        src2      = 32'h0000_0F0F;
        @(posedge clk);
        #1;
        funct = 2'd0;
        src1  = 32'd1;
        src2  = 32'd2;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("stall_latency", lat, 1);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("stall_valid%0d", c), {31'd0, out_valid}, 32'd1);
            check($sformatf("stall_result%0d", c), result, 32'hF0F0_0F0F);
            check($sformatf("stall_in_ready%0d", c), {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("next_accept", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("next_valid", {31'd0, out_valid}, 32'd1);
        check("next_result", result, 32'd3);
        @(posedge clk);
        #1;

        // Reset in the middle of a shift by 20.
        @(negedge clk);
        in_valid = 1'b1;
        funct    = 2'd2;
        src1     = 32'h0000_00FF;
        src2     = 32'd20;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_idle", {31'd0, in_ready}, 32'd1);
        run_op("after_rst_add", 2'd0, 32'd1, 32'd1, 32'd2, 1'b0, 1);

        // Random ops with random downstream stalls.
        received = 0;
        for (int i = 0; i < 30; i++) begin
            rf   = 2'($urandom_range(0, 3));
            ra   = $urandom;
            rb   = $urandom;
            rexp = ref_alu(rf, ra, rb);
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = 1'b1;
            funct     = rf;
            src1      = ra;
            src2      = rb;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            src1     = ~ra;
            src2     = ~rb;
            got = 1'b0;
            for (int c = 0; c < 120 && !got; c++) begin
                @(negedge clk);
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin
                    check($sformatf("rand%0d_result", i), result, rexp);
                    got = 1'b1;
                    received++;
                end
                @(posedge clk);
                #1;
            end
            check($sformatf("rand%0d_no_dup", i), {31'd0, out_valid}, 32'd0);
        end
        check("rand_received", received, 30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
